// File: rtl/sme_job_driver.sv
// -----------------------------------------------------------------------------
// sme_job_driver
//   Host-side initiator for the string matching engine. The host appends
//   characters to a string buffer and a pattern buffer while the driver is
//   idle, then issues start. The driver streams the string and the pattern to
//   the engine back to back, waits for the engine's valid strobe (bounded by
//   a timeout), captures the result and pulses done for one cycle.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   wr_en, wr_sel, wr_data  host append (sel 0: string, 1: pattern), IDLE only
//   wr_err                  one-cycle pulse when a write was dropped
//   start                   launch a job, sampled only in IDLE
//   busy                    high in every state except IDLE
//   done, err, timeout      job-end pulse with its error/timeout qualifiers
//   result_match/_index     captured engine result, held until next start
//   chardata, isstring,     registered character stream to the engine
//   ispattern
//   valid, match,           engine result strobe and qualified result
//   match_index
// -----------------------------------------------------------------------------
module sme_job_driver #(
  parameter int BYTE           = 8,
  parameter int STR_LENGTH     = 32,
  parameter int PATTERN_LENGTH = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [BYTE-1:0] wr_data,
  output logic            wr_err,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            timeout,
  output logic            result_match,
  output logic [4:0]      result_index,
  output logic [BYTE-1:0] chardata,
  output logic            isstring,
  output logic            ispattern,
  input  logic            valid,
  input  logic            match,
  input  logic [4:0]      match_index
);

  // state    | meaning
  // ---------+--------------------------------------------------------------
  // S_IDLE   | accept host writes, wait for start
  // S_SEND_STR| string characters on the engine port (isstring high)
  // S_SEND_PAT| pattern characters on the engine port (ispattern high)
  // S_WAIT_RES| strobes low, engine matching; count towards timeout
  // S_DONE   | one-cycle done pulse, buffers emptied

  localparam int SLW = $clog2(STR_LENGTH + 1);
  localparam int PLW = $clog2(PATTERN_LENGTH + 1);
  localparam int SAW = $clog2(STR_LENGTH);
  localparam int PAW = $clog2(PATTERN_LENGTH);
  localparam int IW  = (SLW > PLW) ? SLW : PLW;
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [SLW-1:0] STR_FULL = SLW'(STR_LENGTH);
  localparam logic [PLW-1:0] PAT_FULL = PLW'(PATTERN_LENGTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SLW-1:0]  str_len_q, str_len_d;
  logic [PLW-1:0]  pat_len_q, pat_len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BYTE-1:0] chardata_q, chardata_d;
  logic            isstring_q, isstring_d;
  logic            ispattern_q, ispattern_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            timeout_q, timeout_d;
  logic            wr_err_q, wr_err_d;
  logic            res_match_q, res_match_d;
  logic [4:0]      res_index_q, res_index_d;

  logic [BYTE-1:0] str_buf_q [STR_LENGTH];
  logic [BYTE-1:0] pat_buf_q [PATTERN_LENGTH];

  logic            str_wr;
  logic            pat_wr;
  logic [IW-1:0]   str_len_ext;
  logic [IW-1:0]   pat_len_ext;

  // A write lands only in IDLE and only while its buffer has room.
  assign str_wr = wr_en && (state_q == S_IDLE) && !wr_sel && (str_len_q < STR_FULL);
  assign pat_wr = wr_en && (state_q == S_IDLE) &&  wr_sel && (pat_len_q < PAT_FULL);

  assign str_len_ext = IW'(str_len_q);
  assign pat_len_ext = IW'(pat_len_q);

  always_ff @(posedge clk) begin
    if (str_wr) str_buf_q[str_len_q[SAW-1:0]] <= wr_data;
    if (pat_wr) pat_buf_q[pat_len_q[PAW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The engine-port registers are loaded with the value for the *next* cycle,
  // so the first string character appears the cycle after start is sampled
  // and the string/pattern hand-over has no idle gap.
  always_comb begin
    state_d     = state_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    chardata_d  = '0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    wr_err_d    = wr_en && !(str_wr || pat_wr);
    res_match_d = res_match_q;
    res_index_d = res_index_q;

    case (state_q)
      S_IDLE: begin
        if (str_wr) str_len_d = str_len_q + SLW'(1);
        if (pat_wr) pat_len_d = pat_len_q + PLW'(1);
        // start looks at the lengths before any same-cycle write
        if (start) begin
          res_match_d = 1'b0;
          res_index_d = '0;
          if ((str_len_q != '0) && (pat_len_q != '0)) begin
            state_d    = S_SEND_STR;
            chardata_d = str_buf_q[0];
            isstring_d = 1'b1;
            idx_d      = IW'(1);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_SEND_STR: begin
        if (idx_q == str_len_ext) begin
          state_d     = S_SEND_PAT;
          chardata_d  = pat_buf_q[0];
          ispattern_d = 1'b1;
          idx_d       = IW'(1);
        end else begin
          chardata_d = str_buf_q[idx_q[SAW-1:0]];
          isstring_d = 1'b1;
          idx_d      = idx_q + IW'(1);
        end
      end

      S_SEND_PAT: begin
        if (idx_q == pat_len_ext) begin
          state_d = S_WAIT_RES;
          cnt_d   = '0;
        end else begin
          chardata_d  = pat_buf_q[idx_q[PAW-1:0]];
          ispattern_d = 1'b1;
          idx_d       = idx_q + IW'(1);
        end
      end

      S_WAIT_RES: begin
        if (valid) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          res_match_d = match;
          res_index_d = match_index;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        str_len_d = '0;
        pat_len_d = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_len_q   <= '0;
      pat_len_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
    end else begin
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      wr_err_q    <= wr_err_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign timeout      = timeout_q;
  assign wr_err       = wr_err_q;
  assign result_match = res_match_q;
  assign result_index = res_index_q;
  assign chardata     = chardata_q;
  assign isstring     = isstring_q;
  assign ispattern    = ispattern_q;

endmodule
